// File: rtl/balabar_pkg.sv
// Shared types for the BalaBar elevator scheduler: car command encodings and FSM states.
package balabar_pkg;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b11;
    localparam logic [1:0] CMD_DOWN = 2'b10;

    // ST_ prefix keeps the state names clear of the command encodings above.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_UP,
        ST_CMD_DN,
        ST_SETTLE,
        ST_ARRIVE,
        ST_DOOR,
        ST_FAULT
    } sched_state_t;

endpackage

// File: rtl/balabar_scheduler_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module balabar_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/balabar_scheduler.sv
// SCAN-ordered elevator scheduler driving the BalaBar car command.
// Optional fire-service recall is enabled by defining BALABAR_SCHED_FIRE_EN.
module balabar_scheduler
    import balabar_pkg::*;
#(
    parameter int FLOORS       = 5,
    parameter int FLOOR_W      = 5,
    parameter int DWELL_CYCLES = 8,
    parameter int SETTLE_MAX   = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef BALABAR_SCHED_FIRE_EN
    input  logic               fire,
`endif
    input  logic [FLOORS-1:0]  call_req,
    input  logic [FLOOR_W-1:0] floor_cur,
    output logic [1:0]         car_cmd,
    output logic [FLOORS-1:0]  pending,
    output logic               door_open,
    output logic               dir_up,
    output logic               fault
);

    localparam int TMR_MAX = (DWELL_CYCLES > SETTLE_MAX) ? DWELL_CYCLES : SETTLE_MAX;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    sched_state_t       state_q, state_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic               dir_up_q, dir_up_d;
    logic [FLOOR_W-1:0] floor_ref_q, floor_ref_d;

    logic [FLOORS-1:0]  here_mask, above_mask, below_mask;
    logic               floor_ok, at_top, at_bottom;
    logic               call_here, call_above, call_below, call_req_here;
    logic               dwell_load, dwell_done, settle_load, settle_done;

    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_mask
            assign here_mask[gi]  = (floor_cur == FLOOR_W'(gi));
            assign above_mask[gi] = (FLOOR_W'(gi) > floor_cur);
            assign below_mask[gi] = (FLOOR_W'(gi) < floor_cur);
        end
    endgenerate

    assign floor_ok      = (floor_cur < FLOOR_W'(FLOORS));
    assign at_top        = (floor_cur == FLOOR_W'(FLOORS - 1));
    assign at_bottom     = (floor_cur == '0);
    assign call_here     = |(pending_q & here_mask);
    assign call_above    = |(pending_q & above_mask);
    assign call_below    = |(pending_q & below_mask);
    assign call_req_here = |(call_req & here_mask);

`ifdef BALABAR_SCHED_FIRE_EN
    logic fire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        dir_up_d    = dir_up_q;
        floor_ref_d = floor_ref_q;
        settle_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (call_here) begin
                    state_d = ST_DOOR;
                end else if (call_above && (dir_up_q || !call_below) && !at_top) begin
                    state_d  = ST_CMD_UP;
                    dir_up_d = 1'b1;
                end else if (call_below && !at_bottom) begin
                    state_d  = ST_CMD_DN;
                    dir_up_d = 1'b0;
                end
            end
            ST_CMD_UP, ST_CMD_DN: begin
                // Reference floor is taken before the car reacts to the command.
                floor_ref_d = floor_cur;
                settle_load = 1'b1;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (floor_cur != floor_ref_q) begin
                    state_d = ST_ARRIVE;
                end else if (settle_done) begin
                    state_d = ST_FAULT;
                end
            end
            ST_ARRIVE: begin
                if (call_here) begin
                    state_d = ST_DOOR;
                end else if (dir_up_q && call_above && !at_top) begin
                    state_d = ST_CMD_UP;
                end else if (!dir_up_q && call_below && !at_bottom) begin
                    state_d = ST_CMD_DN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DOOR: begin
                if (dwell_done && !call_req_here) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase

`ifdef BALABAR_SCHED_FIRE_EN
        // Recall to the ground floor; moves already in flight finish through SETTLE.
        if (state_q != ST_FAULT) begin
            if (fire) begin
                dir_up_d = 1'b0;
                if ((state_q == ST_IDLE) || (state_q == ST_ARRIVE) || (state_q == ST_DOOR)) begin
                    state_d = at_bottom ? ST_DOOR : ST_CMD_DN;
                end
            end else if (fire_q && (state_q == ST_DOOR)) begin
                state_d = ST_IDLE;
            end
        end
`endif

        if (!floor_ok) begin
            state_d = ST_FAULT;
        end

        dwell_load = ((state_d == ST_DOOR) && (state_q != ST_DOOR)) ||
                     ((state_q == ST_DOOR) && call_req_here);

        // Calls for the floor whose door is opening are served, not latched.
        pending_d = pending_q | call_req;
        if ((state_q == ST_DOOR) || (state_d == ST_DOOR)) begin
            pending_d = pending_d & ~here_mask;
        end
`ifdef BALABAR_SCHED_FIRE_EN
        if (fire) begin
            pending_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            dir_up_q    <= 1'b1;
            floor_ref_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            dir_up_q    <= dir_up_d;
            floor_ref_q <= floor_ref_d;
        end
    end

    balabar_dwell_timer #(.W(TMR_W)) u_dwell (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (dwell_load),
        .load_val_i (TMR_W'(DWELL_CYCLES - 1)),
        .en_i       (state_q == ST_DOOR),
        .done_o     (dwell_done)
    );

    balabar_dwell_timer #(.W(TMR_W)) u_settle (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (settle_load),
        .load_val_i (TMR_W'(SETTLE_MAX - 1)),
        .en_i       (state_q == ST_SETTLE),
        .done_o     (settle_done)
    );

    always_comb begin
        case (state_q)
            ST_CMD_UP: car_cmd = CMD_UP;
            ST_CMD_DN: car_cmd = CMD_DOWN;
            default:   car_cmd = CMD_STOP;
        endcase
    end

    assign pending   = pending_q;
    assign door_open = (state_q == ST_DOOR);
    assign dir_up    = dir_up_q;
    assign fault     = (state_q == ST_FAULT);

endmodule
